usr_h2c0_gen: RTL and testbench
===============================

USR_H2C0_GEN -- requirements
Module: usr_h2c0_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, stream data width in bits (only 64 supported).
REQ-002 SHALL have parameter KEEP_WIDTH, default 8, byte-enable width, DATA_WIDTH/8.
REQ-003 SHALL have port usr_clk  in  1  single clock; every register is clocked on its rising edge.
REQ-004 SHALL have port usr_rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port gen_run_i  in  1  run level; rising edge starts a run, falling edge aborts it.
REQ-006 SHALL have port gen_rst_i  in  1  soft clear, same effect as abort.
REQ-007 SHALL have port gen_len_i  in  16  packet length in bytes, sampled at start.
REQ-008 SHALL have port gen_pkt_num_i  in  16  packets per run, sampled at start; 0 = continuous.
REQ-009 SHALL have port m0_axis_h2c_tdata_o  out  DATA_WIDTH  stream data.
REQ-010 SHALL have port m0_axis_h2c_tkeep_o  out  KEEP_WIDTH  byte enables.
REQ-011 SHALL have port m0_axis_h2c_tlast_o  out  1  last beat of packet.
REQ-012 SHALL have port m0_axis_h2c_tvalid_o  out  1  beat valid.
REQ-013 SHALL have port m0_axis_h2c_tready_i  in  1  downstream ready.
REQ-014 SHALL have port gen_busy_o  out  1  high while a run is active.
REQ-015 SHALL have port gen_done_o  out  1  one-cycle pulse at normal run completion.
REQ-016 SHALL have port gen_pkt_cnt_o  out  32  packets completed this run.
REQ-017 SHALL have port gen_byte_cnt_o  out  32  bytes transferred this run.

Function
REQ-018 SHALL register gen_run_i once (run_d1); start = run & ~run_d1, abort = (~run & run_d1) | gen_rst_i.
REQ-019 SHALL implement FSM IDLE, SEND, GAP, DONE; all outputs registered.
REQ-020 IDLE: on start with gen_len_i!=0, latch len/pkt_num, rem=len, go SEND; with gen_len_i==0, go DONE.
REQ-021 SEND: tvalid=1; beat completes only when tvalid & tready; tdata/tkeep/tlast held stable while tready=0.
REQ-022 Beat lanes: lane k valid iff k < min(rem,8); tkeep contiguous from bit 0; invalid lanes data 8'h00.
REQ-023 Lane k data = (pat + k) mod 256, pat an 8-bit running byte counter, 0 at run start, continuous across packets.
REQ-024 On handshake: pat += popcount(tkeep) mod 256, byte_cnt += popcount(tkeep), rem -= popcount(tkeep).
REQ-025 tlast=1 iff rem<=8 on the current beat; on tlast handshake pkt_cnt += 1.
REQ-026 After tlast: if pkt_num!=0 and pkt_cnt+1==pkt_num go DONE, else rem=len, go GAP.
REQ-027 GAP: exactly one cycle tvalid=0, then SEND.
REQ-028 DONE: gen_done_o=1 for one cycle, then IDLE; counters hold their final values until next start or abort.
REQ-029 Abort in any state: next cycle IDLE, tvalid=0, tlast=0, pat/rem/pkt_cnt/byte_cnt=0, no done pulse; abort wins over simultaneous handshake.
REQ-030 Start while busy SHALL be ignored (only possible after an abort/done cycle).
REQ-031 First tvalid SHALL appear the cycle after start is detected (2 cycles after gen_run_i rises).
REQ-032 gen_busy_o=1 in SEND and GAP; 0 in IDLE and DONE.
REQ-033 Counters SHALL wrap modulo 2^32; pat wraps modulo 256 with no flag.

Reset
REQ-034 On usr_rst=1 at a clock edge: FSM IDLE; tvalid, tlast, busy, done = 0; tdata=0, tkeep=0; pat, rem, run_d1, pkt_cnt, byte_cnt = 0.
REQ-035 Reset mid-packet SHALL drop tvalid the following cycle with no further beats.

Verification
REQ-036 len=20, pkt_num=1, tready=1 -> 3 beats: tkeep FF/FF/0F, bytes 0x00..0x13, tlast on beat 3, done pulse, pkt_cnt=1, byte_cnt=20.
REQ-037 len=8, pkt_num=3 -> 3 single-beat packets with 1-cycle gaps; beat 2 tdata=64'h0F0E0D0C0B0A0908; pkt_cnt=3.
REQ-038 len=16, tready toggles 1/0 each cycle -> beat data/tkeep stable across stalls; byte_cnt=16, no lost or duplicated byte.
REQ-039 pkt_num=0, len=300, run held 2000 cycles -> continuous packets, pattern wraps 0xFF->0x00 seamlessly, no done pulse.
REQ-040 gen_run_i falls mid-packet -> tvalid=0 next cycle, counters 0; subsequent restart begins at byte 0x00.
REQ-041 len=0 start -> no tvalid, done pulse 2 cycles after run rises, counters 0.

Source files
------------

// File: rtl/usr_h2c0_gen.sv
// usr_h2c0_gen: host-to-card AXI-Stream traffic generator.
//
// Emits packets of gen_len_i bytes on a 64-bit AXI-Stream master. Each
// payload byte comes from an 8-bit running counter. The counter starts at
// 0 at run start and continues across packet boundaries. A rising edge on
// gen_run_i starts a run. A falling edge, or gen_rst_i, aborts it.
//
// Ports
//   usr_clk, usr_rst        : clock, synchronous active-high reset
//   gen_run_i, gen_rst_i    : run level, soft clear
//   gen_len_i, gen_pkt_num_i: packet length (bytes), packets per run (0 = forever)
//   m0_axis_h2c_*           : AXI-Stream master (tdata/tkeep/tlast/tvalid out, tready in)
//   gen_busy_o, gen_done_o  : run active, one-cycle completion pulse
//   gen_pkt_cnt_o           : packets completed in the current run
//   gen_byte_cnt_o          : bytes transferred in the current run
module usr_h2c0_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = 8
) (
  input  logic                  usr_clk,
  input  logic                  usr_rst,
  input  logic                  gen_run_i,
  input  logic                  gen_rst_i,
  input  logic [15:0]           gen_len_i,
  input  logic [15:0]           gen_pkt_num_i,
  output logic [DATA_WIDTH-1:0] m0_axis_h2c_tdata_o,
  output logic [KEEP_WIDTH-1:0] m0_axis_h2c_tkeep_o,
  output logic                  m0_axis_h2c_tlast_o,
  output logic                  m0_axis_h2c_tvalid_o,
  input  logic                  m0_axis_h2c_tready_i,
  output logic                  gen_busy_o,
  output logic                  gen_done_o,
  output logic [31:0]           gen_pkt_cnt_o,
  output logic [31:0]           gen_byte_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  run_d1_q;
  logic [15:0]           len_q, len_d;
  logic [15:0]           pkt_num_q, pkt_num_d;
  logic [15:0]           rem_q, rem_d;
  logic [7:0]            pat_q, pat_d;
  logic [31:0]           pkt_cnt_q, pkt_cnt_d;
  logic [31:0]           byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
  logic                  tlast_q, tlast_d;
  logic                  tvalid_q, tvalid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  start_s, abort_s, hs_s;
  logic [3:0]            beat_cnt_s;

  // Lane k is valid when k < min(rem, 8). With k < 8 this reduces to k < rem.
  function automatic logic [KEEP_WIDTH-1:0] beat_keep(input logic [15:0] rem);
    logic [KEEP_WIDTH-1:0] keep;
    keep = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) keep[k] = (16'(k) < rem);
    return keep;
  endfunction

  // Valid lane k carries pat+k (mod 256). Invalid lanes are zero.
  function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [7:0] pat,
                                                      input logic [KEEP_WIDTH-1:0] keep);
    logic [DATA_WIDTH-1:0] data;
    data = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) data[8*k +: 8] = keep[k] ? (pat + 8'(k)) : 8'h00;
    return data;
  endfunction

  function automatic logic [3:0] popcount(input logic [KEEP_WIDTH-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int k = 0; k < KEEP_WIDTH; k++) c = c + {3'd0, v[k]};
    return c;
  endfunction

  assign start_s    = gen_run_i & ~run_d1_q;
  assign abort_s    = (~gen_run_i & run_d1_q) | gen_rst_i;
  assign hs_s       = tvalid_q & m0_axis_h2c_tready_i;
  assign beat_cnt_s = popcount(tkeep_q);

  // Next-state, counter and output-register logic.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    pkt_num_d  = pkt_num_q;
    rem_d      = rem_q;
    pat_d      = pat_q;
    pkt_cnt_d  = pkt_cnt_q;
    byte_cnt_d = byte_cnt_q;
    tdata_d    = tdata_q;
    tkeep_d    = tkeep_q;
    tlast_d    = tlast_q;
    tvalid_d   = tvalid_q;
    done_d     = 1'b0;

    if (abort_s) begin
      // Abort takes priority over any handshake in the same cycle.
      state_d    = S_IDLE;
      rem_d      = 16'd0;
      pat_d      = 8'd0;
      pkt_cnt_d  = 32'd0;
      byte_cnt_d = 32'd0;
      tdata_d    = '0;
      tkeep_d    = '0;
      tlast_d    = 1'b0;
      tvalid_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_s) begin
            pat_d      = 8'd0;
            pkt_cnt_d  = 32'd0;
            byte_cnt_d = 32'd0;
            if (gen_len_i != 16'd0) begin
              len_d     = gen_len_i;
              pkt_num_d = gen_pkt_num_i;
              rem_d     = gen_len_i;
              state_d   = S_SEND;
            end else begin
              rem_d   = 16'd0;
              state_d = S_DONE;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SEND: begin
          if (!tvalid_q) begin
            // First cycle after start: present the first beat.
            tkeep_d  = beat_keep(rem_q);
            tdata_d  = beat_data(pat_q, beat_keep(rem_q));
            tlast_d  = (rem_q <= 16'd8);
            tvalid_d = 1'b1;
          end else if (hs_s) begin
            pat_d      = pat_q + {4'd0, beat_cnt_s};
            byte_cnt_d = byte_cnt_q + {28'd0, beat_cnt_s};
            rem_d      = rem_q - {12'd0, beat_cnt_s};
            if (tlast_q) begin
              pkt_cnt_d = pkt_cnt_q + 32'd1;
              tdata_d   = '0;
              tkeep_d   = '0;
              tlast_d   = 1'b0;
              tvalid_d  = 1'b0;
              if ((pkt_num_q != 16'd0) && ((pkt_cnt_q + 32'd1) == {16'd0, pkt_num_q})) begin
                state_d = S_DONE;
              end else begin
                rem_d   = len_q;
                state_d = S_GAP;
              end
            end else begin
              // Present the next beat back to back.
              tkeep_d = beat_keep(rem_d);
              tdata_d = beat_data(pat_d, beat_keep(rem_d));
              tlast_d = (rem_d <= 16'd8);
            end
          end else begin
            // Stalled: hold the current beat.
            state_d = S_SEND;
          end
        end
        S_GAP: begin
          // This is the single idle cycle. Load the first beat of the next packet now.
          tkeep_d  = beat_keep(rem_q);
          tdata_d  = beat_data(pat_q, beat_keep(rem_q));
          tlast_d  = (rem_q <= 16'd8);
          tvalid_d = 1'b1;
          state_d  = S_SEND;
        end
        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d == S_SEND) || (state_d == S_GAP);
  end

  // State, counter and output registers.
  always_ff @(posedge usr_clk) begin
    if (usr_rst) begin
      state_q    <= S_IDLE;
      run_d1_q   <= 1'b0;
      len_q      <= 16'd0;
      pkt_num_q  <= 16'd0;
      rem_q      <= 16'd0;
      pat_q      <= 8'd0;
      pkt_cnt_q  <= 32'd0;
      byte_cnt_q <= 32'd0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tlast_q    <= 1'b0;
      tvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_d1_q   <= gen_run_i;
      len_q      <= len_d;
      pkt_num_q  <= pkt_num_d;
      rem_q      <= rem_d;
      pat_q      <= pat_d;
      pkt_cnt_q  <= pkt_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      tlast_q    <= tlast_d;
      tvalid_q   <= tvalid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign m0_axis_h2c_tdata_o  = tdata_q;
  assign m0_axis_h2c_tkeep_o  = tkeep_q;
  assign m0_axis_h2c_tlast_o  = tlast_q;
  assign m0_axis_h2c_tvalid_o = tvalid_q;
  assign gen_busy_o           = busy_q;
  assign gen_done_o           = done_q;
  assign gen_pkt_cnt_o        = pkt_cnt_q;
  assign gen_byte_cnt_o       = byte_cnt_q;

endmodule

// File: tb/tb_usr_h2c0_gen.sv
// Testbench for usr_h2c0_gen.
// Stimulus is a mix of directed and randomized runs. The reference model works
// at byte-stream level: it tracks the offset in the packet, the global byte
// index and the packet count. Expected beats, counters and timing come from those.
module tb_usr_h2c0_gen;

  logic        usr_clk = 1'b0;
  logic        usr_rst;
  logic        gen_run_i;
  logic        gen_rst_i;
  logic [15:0] gen_len_i;
  logic [15:0] gen_pkt_num_i;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic        busy;
  logic        done;
  logic [31:0] pkt_cnt;
  logic [31:0] byte_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 usr_clk = ~usr_clk;

  usr_h2c0_gen #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) u_dut (
    .usr_clk              (usr_clk),
    .usr_rst              (usr_rst),
    .gen_run_i            (gen_run_i),
    .gen_rst_i            (gen_rst_i),
    .gen_len_i            (gen_len_i),
    .gen_pkt_num_i        (gen_pkt_num_i),
    .m0_axis_h2c_tdata_o  (tdata),
    .m0_axis_h2c_tkeep_o  (tkeep),
    .m0_axis_h2c_tlast_o  (tlast),
    .m0_axis_h2c_tvalid_o (tvalid),
    .m0_axis_h2c_tready_i (tready),
    .gen_busy_o           (busy),
    .gen_done_o           (done),
    .gen_pkt_cnt_o        (pkt_cnt),
    .gen_byte_cnt_o       (byte_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge usr_clk);
    #1;
  endtask

  task automatic idle();
    gen_run_i = 1'b0;
    gen_rst_i = 1'b0;
    usr_rst   = 1'b0;
    step();
    step();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("idle_byte_cnt", 64'(byte_cnt), 64'd0);
  endtask

  // Run one generator session.
  //   rdy  : tready percentage, or -1 to toggle every cycle
  //   kind : 0 = run to completion, 1 = drop gen_run_i, 2 = gen_rst_i pulse, 3 = usr_rst
  //   stop_beats / hold : stop after this many beats / cycles (0 = unused)
  task automatic do_run(input int len, input int num, input int rdy,
                        input int kind, input int stop_beats, input int hold);
    int          off, gb, pkts, beats, cyc, gap, n;
    logic [63:0] edata;
    logic [7:0]  ekeep;
    bit          elast;
    bit          stop;
    off = 0; gb = 0; pkts = 0; beats = 0; cyc = 0; gap = 0;
    gen_len_i     = 16'(len);
    gen_pkt_num_i = 16'(num);
    gen_run_i     = 1'b1;
    tready        = 1'b1;
    step();
    chk("start_tvalid", 64'(tvalid), 64'd0);
    chk("start_busy", 64'(busy), 64'(len != 0));
    step();
    if (len == 0) begin
      chk("zlen_done", 64'(done), 64'd1);
      chk("zlen_tvalid", 64'(tvalid), 64'd0);
      chk("zlen_pkt_cnt", 64'(pkt_cnt), 64'd0);
      chk("zlen_byte_cnt", 64'(byte_cnt), 64'd0);
      step();
      chk("zlen_done_end", 64'(done), 64'd0);
      return;
    end
    chk("first_tvalid", 64'(tvalid), 64'd1);
    forever begin
      if (cyc >= 20000) begin
        chk("run_timeout_pkts", 64'(pkts), 64'(num));
        return;
      end
      stop = (kind != 0) && ((stop_beats != 0 && beats >= stop_beats) ||
                             (hold != 0 && cyc >= hold));
      if (stop) begin
        case (kind)
          1: gen_run_i = 1'b0;
          2: gen_rst_i = 1'b1;
          default: usr_rst = 1'b1;
        endcase
        step();
        chk("abort_tvalid", 64'(tvalid), 64'd0);
        chk("abort_tlast", 64'(tlast), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("abort_byte_cnt", 64'(byte_cnt), 64'd0);
        gen_rst_i = 1'b0;
        usr_rst   = 1'b0;
        return;
      end
      if (rdy < 0) tready = ~tready;
      else         tready = ($urandom_range(0, 99) < rdy);
      chk("busy", 64'(busy), 64'd1);
      chk("no_done", 64'(done), 64'd0);
      chk("pkt_cnt", 64'(pkt_cnt), 64'(pkts));
      chk("byte_cnt", 64'(byte_cnt), 64'(gb));
      if (gap == 1) begin
        chk("gap_tvalid", 64'(tvalid), 64'd0);
        gap = 0;
      end else begin
        n = (len - off < 8) ? (len - off) : 8;
        ekeep = 8'h00;
        edata = 64'd0;
        for (int k = 0; k < n; k++) begin
          ekeep[k] = 1'b1;
          edata[8*k +: 8] = 8'((gb + k) % 256);
        end
        elast = (off + n == len);
        chk("tvalid", 64'(tvalid), 64'd1);
        chk("tdata", tdata, edata);
        chk("tkeep", 64'(tkeep), 64'(ekeep));
        chk("tlast", 64'(tlast), 64'(elast));
        if (tready) begin
          off += n; gb += n; beats++;
          if (elast) begin
            off = 0;
            pkts++;
            if (num != 0 && pkts == num) begin
              step();
              chk("end_tvalid", 64'(tvalid), 64'd0);
              chk("end_busy", 64'(busy), 64'd0);
              chk("end_done_early", 64'(done), 64'd0);
              chk("end_pkt_cnt", 64'(pkt_cnt), 64'(num));
              chk("end_byte_cnt", 64'(byte_cnt), 64'(num * len));
              step();
              chk("done_pulse", 64'(done), 64'd1);
              chk("done_busy", 64'(busy), 64'd0);
              step();
              chk("done_low", 64'(done), 64'd0);
              chk("hold_pkt_cnt", 64'(pkt_cnt), 64'(num));
              chk("hold_byte_cnt", 64'(byte_cnt), 64'(num * len));
              return;
            end
            gap = 1;
          end
        end
      end
      cyc++;
      step();
    end
  endtask

  initial begin
    usr_rst       = 1'b1;
    gen_run_i     = 1'b0;
    gen_rst_i     = 1'b0;
    gen_len_i     = 16'd0;
    gen_pkt_num_i = 16'd0;
    tready        = 1'b0;
    step();
    step();
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_tdata", tdata, 64'd0);
    chk("rst_tkeep", 64'(tkeep), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_byte_cnt", 64'(byte_cnt), 64'd0);
    usr_rst = 1'b0;
    step();

    do_run(20, 1, 100, 0, 0, 0);     idle();  // three beats FF/FF/0F
    do_run(8, 3, 100, 0, 0, 0);      idle();  // single-beat packets with gaps
    do_run(16, 1, -1, 0, 0, 0);      idle();  // tready toggling
    do_run(300, 0, 100, 1, 0, 2000); idle();  // continuous, pattern wraps
    do_run(40, 2, 100, 1, 3, 0);     idle();  // run falls mid-packet
    do_run(20, 1, 100, 0, 0, 0);     idle();  // restart begins at byte 0
    do_run(0, 1, 100, 0, 0, 0);      idle();  // zero length
    do_run(24, 2, 100, 2, 2, 0);     idle();  // soft clear mid-run
    do_run(30, 1, 70, 3, 2, 0);      idle();  // reset mid-packet
    do_run(9, 0, 60, 1, 0, 150);     idle();  // continuous with 1-byte tails

    for (int i = 0; i < 12; i++) begin
      do_run($urandom_range(1, 40), $urandom_range(1, 4), $urandom_range(30, 100), 0, 0, 0);
      idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
